// File: rtl/qpll_seq_pkg.sv
// rtl/qpll_seq_pkg.sv - shared types and helpers for the QPLL reset sequencer
package qpll_seq_pkg;

    typedef enum logic [2:0] {
        PWRDN,
        RESET,
        WAIT_LOCK,
        SETTLE,
        READY,
        FAULT
    } qpll_state_t;

    localparam int RETRY_W = 4;
    localparam int LOST_W  = 16;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - two-flop synchronizer, async active-low reset to 0
module bit_synchronizer (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/qpll_reset_sequencer.sv
// rtl/qpll_reset_sequencer.sv - QPLL power-up/reset sequencing, lock supervision and relock arbitration
module qpll_reset_sequencer
    import qpll_seq_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int PD_CYCLES     = 500,
    parameter int RESET_CYCLES  = 50,
    parameter int LOCK_TIMEOUT  = 200000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    qpll_lock,
    input  logic                    qpll_refclk_lost,
    input  logic [NUM_CHANNELS-1:0] ch_relock_req,
    input  logic                    fault_clear,
    output logic                    qpll_pd,
    output logic                    qpll_reset,
    output logic                    qpll_ready,
    output logic [NUM_CHANNELS-1:0] ch_relock_ack,
    output logic                    fault,
    output logic [RETRY_W-1:0]      retry_count,
    output logic [LOST_W-1:0]       lock_lost_count
);

    localparam int TIMER_W = $clog2(max_of4(PD_CYCLES, RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;
    localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [TIMER_W-1:0] PD_LAST      = TIMER_W'(PD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);

    logic lock_s;
    logic lost_s;

    bit_synchronizer u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (qpll_lock),
        .q_o   (lock_s)
    );

    bit_synchronizer u_sync_lost (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (qpll_refclk_lost),
        .q_o   (lost_s)
    );

    qpll_state_t               state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic [LOST_W-1:0]         lost_q, lost_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [NUM_CHANNELS-1:0]   blocked_q, blocked_d;
    logic [NUM_CHANNELS-1:0]   ack_q, ack_d;
    logic                      pd_q, rst_q, ready_q, fault_q;

    logic [NUM_CHANNELS-1:0]   eligible;
    logic                      grant_valid, wrap_valid;
    logic [IDX_W-1:0]          grant_idx, wrap_idx;
    logic [RETRY_W:0]          retry_inc;

    // A granted channel stays masked until it drops its request, so a level
    // held across the relock it caused cannot win a second grant.
    assign eligible = ch_relock_req & ~blocked_q;

    // Round-robin: lowest eligible index at or above the pointer, else wrap to
    // the lowest eligible index below it.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        wrap_valid  = 1'b0;
        wrap_idx    = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                if (i >= int'(ptr_q)) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(i);
                end else begin
                    wrap_valid = 1'b1;
                    wrap_idx   = IDX_W'(i);
                end
            end
        end
        if (!grant_valid) begin
            grant_valid = wrap_valid;
            grant_idx   = wrap_idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        retry_d   = retry_q;
        lost_d    = lost_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        blocked_d = blocked_q & ch_relock_req;
        retry_inc = {1'b0, retry_q} + (RETRY_W + 1)'(1);

        unique case (state_q)
            PWRDN: begin
                if (timer_q == PD_LAST) state_d = RESET;
            end
            RESET: begin
                if (timer_q == RESET_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s && !lost_s) begin
                    state_d = SETTLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    retry_d = (retry_inc > (RETRY_W + 1)'(15)) ? '1 : retry_inc[RETRY_W-1:0];
                    state_d = (retry_inc > (RETRY_W + 1)'(MAX_RETRIES)) ? FAULT : RESET;
                end
            end
            SETTLE: begin
                if (!lock_s || lost_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = READY;
                    retry_d = '0;
                end
            end
            READY: begin
                // Lock loss outranks a relock request arriving in the same cycle.
                if (!lock_s || lost_s) begin
                    state_d = RESET;
                    if (lost_q != '1) lost_d = lost_q + LOST_W'(1);
                end else if (grant_valid) begin
                    state_d   = RESET;
                    ack_d     = NUM_CHANNELS'(1) << grant_idx;
                    blocked_d = (blocked_q & ch_relock_req) | (NUM_CHANNELS'(1) << grant_idx);
                    ptr_d     = (grant_idx == IDX_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + IDX_W'(1);
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_d = PWRDN;
                    retry_d = '0;
                end
            end
            default: state_d = PWRDN;
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    // Pin-level outputs are decoded from the next state so they change on the
    // same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWRDN;
            timer_q   <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            ptr_q     <= '0;
            blocked_q <= '0;
            ack_q     <= '0;
            pd_q      <= 1'b1;
            rst_q     <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            ptr_q     <= ptr_d;
            blocked_q <= blocked_d;
            ack_q     <= ack_d;
            pd_q      <= (state_d == PWRDN) || (state_d == FAULT);
            rst_q     <= (state_d == PWRDN) || (state_d == RESET) || (state_d == FAULT);
            ready_q   <= (state_d == READY);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign qpll_pd         = pd_q;
    assign qpll_reset      = rst_q;
    assign qpll_ready      = ready_q;
    assign fault           = fault_q;
    assign ch_relock_ack   = ack_q;
    assign retry_count     = retry_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_qpll_reset_sequencer.sv
// tb/tb_qpll_reset_sequencer.sv - self-checking bench for qpll_reset_sequencer
module tb_qpll_reset_sequencer;

    localparam int NCH = 4;
    localparam int PD  = 40;
    localparam int RC  = 50;
    localparam int TO  = 100;
    localparam int S   = 60;
    localparam int MR  = 2;

    localparam int SEL_PD    = 0;
    localparam int SEL_RST   = 1;
    localparam int SEL_READY = 2;
    localparam int SEL_FAULT = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           qpll_lock;
    logic           qpll_refclk_lost;
    logic [NCH-1:0] ch_relock_req;
    logic           fault_clear;
    logic           qpll_pd;
    logic           qpll_reset;
    logic           qpll_ready;
    logic [NCH-1:0] ch_relock_ack;
    logic           fault;
    logic [3:0]     retry_count;
    logic [15:0]    lock_lost_count;

    int cyc      = 0;
    int n_cmp    = 0;
    int n_bad    = 0;
    int exp_lost = 0;
    int rr_ptr   = 0;

    qpll_reset_sequencer #(
        .NUM_CHANNELS  (NCH),
        .PD_CYCLES     (PD),
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (TO),
        .SETTLE_CYCLES (S),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .qpll_lock        (qpll_lock),
        .qpll_refclk_lost (qpll_refclk_lost),
        .ch_relock_req    (ch_relock_req),
        .fault_clear      (fault_clear),
        .qpll_pd          (qpll_pd),
        .qpll_reset       (qpll_reset),
        .qpll_ready       (qpll_ready),
        .ch_relock_ack    (ch_relock_ack),
        .fault            (fault),
        .retry_count      (retry_count),
        .lock_lost_count  (lock_lost_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sig(input int sel);
        case (sel)
            SEL_PD:    return qpll_pd;
            SEL_RST:   return qpll_reset;
            SEL_READY: return qpll_ready;
            default:   return fault;
        endcase
    endfunction

    // Returns the cycle stamp of the first falling edge where the output equals val, or -1.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(sel) === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Round-robin reference: first requester at or after ptr, cyclically.
    function automatic int rr_pick(input logic [NCH-1:0] m, input int ptr);
        logic [NCH-1:0] sh;
        for (int k = 0; k < NCH; k++) begin
            sh = m >> ((ptr + k) % NCH);
            if (sh[0]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; qpll_lock = 1'b0; qpll_refclk_lost = 1'b0;
        ch_relock_req = '0; fault_clear = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (qpll_pd !== 1'b1) begin n_bad++; $display("FAIL reset_pd got %b want 1", qpll_pd); end
        n_cmp++; if (qpll_reset !== 1'b1) begin n_bad++; $display("FAIL reset_rst got %b want 1", qpll_reset); end
        n_cmp++; if (qpll_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", qpll_ready); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fault); end
        n_cmp++; if (ch_relock_ack !== '0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ch_relock_ack); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL reset_retry got %0d want 0", retry_count); end
        n_cmp++; if (lock_lost_count !== 16'd0) begin n_bad++; $display("FAIL reset_lost got %0d want 0", lock_lost_count); end
    endtask

    task automatic test_bringup();
        int t0, t, lock_at, d;
        @(negedge clk);
        rst_n = 1'b1; t0 = cyc;
        wait_sig(SEL_PD, 1'b0, PD + 20, t);
        n_cmp++; if (t != t0 + PD) begin n_bad++; $display("FAIL bringup_pd_fall got %0d want %0d", t, t0 + PD); end
        wait_sig(SEL_RST, 1'b0, RC + 20, t);
        n_cmp++; if (t != t0 + PD + RC) begin n_bad++; $display("FAIL bringup_rst_fall got %0d want %0d", t, t0 + PD + RC); end
        d = $urandom_range(40, 5);
        repeat (d) @(negedge clk);
        qpll_lock = 1'b1; lock_at = cyc;
        wait_sig(SEL_READY, 1'b1, S + 40, t);
        n_cmp++; if (t != lock_at + 2 + S + 1) begin n_bad++; $display("FAIL bringup_ready got %0d want %0d", t, lock_at + 2 + S + 1); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL bringup_retry got %0d want 0", retry_count); end
    endtask

    task automatic test_relock_directed();
        int r, t, a;
        logic ok;
        ch_relock_req = 4'b1010; r = cyc;
        @(negedge clk);
        n_cmp++; if (ch_relock_ack !== 4'b0010) begin n_bad++; $display("FAIL ack_ch1 got %b want 0010", ch_relock_ack); end
        n_cmp++; if (qpll_ready !== 1'b0) begin n_bad++; $display("FAIL ack_ch1_ready got %b want 0", qpll_ready); end
        @(negedge clk);
        n_cmp++; if (ch_relock_ack !== 4'b0000) begin n_bad++; $display("FAIL ack_ch1_width got %b want 0000", ch_relock_ack); end
        wait_sig(SEL_READY, 1'b1, RC + S + 40, t);
        n_cmp++; if (t != r + 2 + RC + S) begin n_bad++; $display("FAIL relock1_ready got %0d want %0d", t, r + 2 + RC + S); end
        @(negedge clk); a = cyc;
        n_cmp++; if (ch_relock_ack !== 4'b1000) begin n_bad++; $display("FAIL ack_ch3 got %b want 1000", ch_relock_ack); end
        rr_ptr = 0;
        wait_sig(SEL_READY, 1'b1, RC + S + 40, t);
        n_cmp++; if (t != a + RC + 1 + S) begin n_bad++; $display("FAIL relock3_ready got %0d want %0d", t, a + RC + 1 + S); end
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ch_relock_ack !== '0 || qpll_ready !== 1'b1) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL held_regrant got %b want 1", ok); end
        ch_relock_req = '0;
        @(negedge clk);
        ch_relock_req = 4'b0101;
        @(negedge clk); a = cyc;
        n_cmp++; if (ch_relock_ack !== 4'b0001) begin n_bad++; $display("FAIL wrap_ack_ch0 got %b want 0001", ch_relock_ack); end
        rr_ptr = 1;
        ch_relock_req = '0;
        wait_sig(SEL_READY, 1'b1, RC + S + 40, t);
        n_cmp++; if (t != a + RC + 1 + S) begin n_bad++; $display("FAIL wrap_ready got %0d want %0d", t, a + RC + 1 + S); end
    endtask

    task automatic test_random_rr();
        logic [NCH-1:0] m, exp_ack;
        int g, a, t;
        for (int it = 0; it < 6; it++) begin
            m = NCH'($urandom_range((1 << NCH) - 1, 1));
            g = rr_pick(m, rr_ptr);
            exp_ack = NCH'(1) << g;
            ch_relock_req = m;
            @(negedge clk); a = cyc;
            n_cmp++; if (ch_relock_ack !== exp_ack) begin n_bad++; $display("FAIL rr_ack req %b got %b want %b", m, ch_relock_ack, exp_ack); end
            rr_ptr = (g + 1) % NCH;
            ch_relock_req = '0;
            wait_sig(SEL_READY, 1'b1, RC + S + 40, t);
            n_cmp++; if (t != a + RC + 1 + S) begin n_bad++; $display("FAIL rr_ready got %0d want %0d", t, a + RC + 1 + S); end
        end
    endtask

    task automatic test_loss_and_req();
        int e, t;
        qpll_lock = 1'b0;
        repeat (2) @(negedge clk);
        ch_relock_req = 4'b0001;
        n_cmp++; if (qpll_ready !== 1'b1) begin n_bad++; $display("FAIL pre_loss_ready got %b want 1", qpll_ready); end
        @(negedge clk);
        exp_lost++;
        n_cmp++; if (ch_relock_ack !== '0) begin n_bad++; $display("FAIL loss_no_ack got %b want 0000", ch_relock_ack); end
        n_cmp++; if (qpll_ready !== 1'b0) begin n_bad++; $display("FAIL loss_ready got %b want 0", qpll_ready); end
        n_cmp++; if (qpll_reset !== 1'b1) begin n_bad++; $display("FAIL loss_reset got %b want 1", qpll_reset); end
        n_cmp++; if (lock_lost_count !== 16'(exp_lost)) begin n_bad++; $display("FAIL loss_count got %0d want %0d", lock_lost_count, exp_lost); end
        ch_relock_req = '0; qpll_lock = 1'b1; e = cyc;
        wait_sig(SEL_READY, 1'b1, RC + S + 40, t);
        n_cmp++; if (t != e + RC + 1 + S) begin n_bad++; $display("FAIL loss_recover got %0d want %0d", t, e + RC + 1 + S); end
        qpll_refclk_lost = 1'b1;
        repeat (3) @(negedge clk);
        exp_lost++;
        n_cmp++; if (lock_lost_count !== 16'(exp_lost)) begin n_bad++; $display("FAIL refclk_count got %0d want %0d", lock_lost_count, exp_lost); end
        n_cmp++; if (qpll_ready !== 1'b0) begin n_bad++; $display("FAIL refclk_ready got %b want 0", qpll_ready); end
        qpll_refclk_lost = 1'b0; e = cyc;
        wait_sig(SEL_READY, 1'b1, RC + S + 40, t);
        n_cmp++; if (t != e + RC + 1 + S) begin n_bad++; $display("FAIL refclk_recover got %0d want %0d", t, e + RC + 1 + S); end
    endtask

    task automatic test_settle_glitch();
        int p, t;
        qpll_lock = 1'b0;
        repeat (3) @(negedge clk);
        exp_lost++;
        repeat (RC + 5) @(negedge clk);
        qpll_lock = 1'b1; p = cyc;
        repeat (20) @(negedge clk);
        qpll_lock = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (qpll_ready !== 1'b0) begin n_bad++; $display("FAIL glitch_ready got %b want 0", qpll_ready); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL glitch_retry got %0d want 0", retry_count); end
        @(negedge clk);
        qpll_lock = 1'b1;
        wait_sig(SEL_READY, 1'b1, S + 40, t);
        n_cmp++; if (t != p + 25 + 3 + S) begin n_bad++; $display("FAIL glitch_ready_time got %0d want %0d", t, p + 28 + S); end
        n_cmp++; if (lock_lost_count !== 16'(exp_lost)) begin n_bad++; $display("FAIL glitch_count got %0d want %0d", lock_lost_count, exp_lost); end
    endtask

    task automatic test_fault_and_reset();
        int tt, t, f, w;
        qpll_lock = 1'b0;
        tt = cyc + 3;
        exp_lost++;
        for (int k = 0; k < MR + 1; k++) begin
            wait_sig(SEL_RST, 1'b1, RC + TO + 20, t);
            n_cmp++; if (t != tt) begin n_bad++; $display("FAIL fault_rst_rise%0d got %0d want %0d", k, t, tt); end
            n_cmp++; if (retry_count !== k[3:0]) begin n_bad++; $display("FAIL fault_retry%0d got %0d want %0d", k, retry_count, k); end
            wait_sig(SEL_RST, 1'b0, RC + 20, t);
            n_cmp++; if (t != tt + RC) begin n_bad++; $display("FAIL fault_rst_fall%0d got %0d want %0d", k, t, tt + RC); end
            tt = tt + RC + TO;
        end
        wait_sig(SEL_FAULT, 1'b1, TO + 20, t);
        n_cmp++; if (t != tt) begin n_bad++; $display("FAIL fault_entry got %0d want %0d", t, tt); end
        n_cmp++; if (qpll_pd !== 1'b1) begin n_bad++; $display("FAIL fault_pd got %b want 1", qpll_pd); end
        n_cmp++; if (qpll_reset !== 1'b1) begin n_bad++; $display("FAIL fault_rst got %b want 1", qpll_reset); end
        n_cmp++; if (retry_count !== 4'(MR + 1)) begin n_bad++; $display("FAIL fault_retry_final got %0d want %0d", retry_count, MR + 1); end
        n_cmp++; if (lock_lost_count !== 16'(exp_lost)) begin n_bad++; $display("FAIL fault_count got %0d want %0d", lock_lost_count, exp_lost); end
        repeat (3) @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0; f = cyc;
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL clear_fault got %b want 0", fault); end
        n_cmp++; if (qpll_pd !== 1'b1) begin n_bad++; $display("FAIL clear_pd got %b want 1", qpll_pd); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL clear_retry got %0d want 0", retry_count); end
        wait_sig(SEL_PD, 1'b0, PD + 20, t);
        n_cmp++; if (t != f + PD) begin n_bad++; $display("FAIL clear_pd_fall got %0d want %0d", t, f + PD); end
        wait_sig(SEL_RST, 1'b0, RC + 20, t);
        w = f + PD + RC;
        n_cmp++; if (t != w) begin n_bad++; $display("FAIL clear_rst_fall got %0d want %0d", t, w); end
        wait_sig(SEL_RST, 1'b1, TO + 20, t);
        n_cmp++; if (t != w + TO) begin n_bad++; $display("FAIL timeout_rst got %0d want %0d", t, w + TO); end
        n_cmp++; if (retry_count !== 4'd1) begin n_bad++; $display("FAIL timeout_retry got %0d want 1", retry_count); end
        wait_sig(SEL_RST, 1'b0, RC + 20, t);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (qpll_pd !== 1'b1) begin n_bad++; $display("FAIL async_pd got %b want 1", qpll_pd); end
        n_cmp++; if (qpll_reset !== 1'b1) begin n_bad++; $display("FAIL async_rst got %b want 1", qpll_reset); end
        n_cmp++; if (retry_count !== 4'd0) begin n_bad++; $display("FAIL async_retry got %0d want 0", retry_count); end
        n_cmp++; if (lock_lost_count !== 16'd0) begin n_bad++; $display("FAIL async_lost got %0d want 0", lock_lost_count); end
        n_cmp++; if (qpll_ready !== 1'b0) begin n_bad++; $display("FAIL async_ready got %b want 0", qpll_ready); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bringup();
        test_relock_directed();
        test_random_rr();
        test_loss_and_req();
        test_settle_glitch();
        test_fault_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
